// File: rtl/piso_stream_serializer_if.sv
// rtl/piso_stream_serializer_if.sv - word-side ready/valid handshake for the serializer
interface piso_stream_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             msb_first;

    modport master (
        output in_valid,
        output in_data,
        output msb_first,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  msb_first,
        output in_ready
    );
endinterface

// File: rtl/piso_stream_serializer.sv
// rtl/piso_stream_serializer.sv - parametrised PISO with ready/valid input and bit-rate strobe
module piso_stream_serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                          clk,
    input  logic                          nrst,
    piso_stream_serializer_if.slave       in_if,
    input  logic                          bit_en,
    output logic                          ser_out,
    output logic                          ser_valid,
    output logic                          done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             order_q, order_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             in_ready;
    logic             accept;

    always_comb begin
        last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        in_ready = nrst && ((state_q == IDLE) || (last_bit && bit_en));
        accept   = in_if.in_valid && in_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        order_d = order_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Loading from idle does not wait for the strobe.
                if (accept) begin
                    sr_d    = in_if.in_data;
                    order_d = in_if.msb_first;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (!last_bit) begin
                        sr_d  = order_q ? (sr_q << 1) : (sr_q >> 1);
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                        if (accept) begin
                            sr_d    = in_if.in_data;
                            order_d = in_if.msb_first;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            order_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            order_q <= order_d;
            done_q  <= done_d;
        end
    end

    assign in_if.in_ready = in_ready;
    assign ser_valid      = (state_q == SHIFT);
    assign ser_out        = (state_q == SHIFT) ? (order_q ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_LEVEL;
    assign done           = done_q;
endmodule

// File: tb/tb_piso_stream_serializer.sv
// tb/tb_piso_stream_serializer.sv - directed self-checking bench for piso_stream_serializer
module tb_piso_stream_serializer;
    logic clk = 1'b0;
    logic nrst;
    logic bit_en;
    logic a_ser_out, a_ser_valid, a_done;
    logic b_ser_out, b_ser_valid, b_done;
    int   checks = 0;
    int   errors = 0;

    piso_stream_serializer_if #(.WIDTH(8)) a_if ();
    piso_stream_serializer_if #(.WIDTH(5)) b_if ();

    piso_stream_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut_a (
        .clk       (clk),
        .nrst      (nrst),
        .in_if     (a_if.slave),
        .bit_en    (bit_en),
        .ser_out   (a_ser_out),
        .ser_valid (a_ser_valid),
        .done      (a_done)
    );

    piso_stream_serializer #(.WIDTH(5), .IDLE_LEVEL(1'b1)) dut_b (
        .clk       (clk),
        .nrst      (nrst),
        .in_if     (b_if.slave),
        .bit_en    (bit_en),
        .ser_out   (b_ser_out),
        .ser_valid (b_ser_valid),
        .done      (b_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge with dut_a idle; seq lists the expected bits left to right.
    task automatic send8(input string tag, input logic [7:0] data, input logic msb,
                         input logic [7:0] seq, input bit toggle);
        a_if.in_valid  = 1'b1;
        a_if.in_data   = data;
        a_if.msb_first = msb;
        bit_en         = 1'b1;
        chk({tag, "_ready"}, a_if.in_ready, 1'b1);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), a_ser_out, seq[7-i]);
            chk($sformatf("%s_val%0d", tag, i), a_ser_valid, 1'b1);
            chk($sformatf("%s_done%0d", tag, i), a_done, 1'b0);
            if (toggle && i == 3) a_if.msb_first = ~msb;
            @(negedge clk);
        end
        chk({tag, "_done"}, a_done, 1'b1);
        chk({tag, "_val_end"}, a_ser_valid, 1'b0);
        chk({tag, "_idle_out"}, a_ser_out, 1'b0);
        @(negedge clk);
        chk({tag, "_done_clr"}, a_done, 1'b0);
    endtask

    initial begin
        logic [15:0] seq16;
        logic [7:0]  seq8;
        logic [4:0]  seq5;

        nrst           = 1'b0;
        bit_en         = 1'b0;
        a_if.in_valid  = 1'b0;
        a_if.in_data   = '0;
        a_if.msb_first = 1'b0;
        b_if.in_valid  = 1'b0;
        b_if.in_data   = '0;
        b_if.msb_first = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_val", a_ser_valid, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_out", a_ser_out, 1'b0);
        chk("rst_ready", a_if.in_ready, 1'b0);
        chk("rst_b_out", b_ser_out, 1'b1);
        chk("rst_b_ready", b_if.in_ready, 1'b0);
        nrst = 1'b1;
        @(negedge clk);
        chk("idle_ready", a_if.in_ready, 1'b1);

        send8("lsb", 8'h1E, 1'b0, 8'b0111_1000, 1'b0);
        send8("msb", 8'h1E, 1'b1, 8'b0001_1110, 1'b1);

        // Back-to-back words with in_valid held high.
        seq16          = 16'b0111_1000_0000_1111;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'h1E;
        a_if.msb_first = 1'b0;
        bit_en         = 1'b1;
        chk("gap_ready0", a_if.in_ready, 1'b1);
        @(negedge clk);
        a_if.in_data = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("gap_bit%0d", i), a_ser_out, seq16[15-i]);
            chk($sformatf("gap_val%0d", i), a_ser_valid, 1'b1);
            chk($sformatf("gap_done%0d", i), a_done, (i == 8));
            chk($sformatf("gap_ready%0d", i), a_if.in_ready, (i == 7 || i == 15));
            if (i == 8) a_if.in_valid = 1'b0;
            @(negedge clk);
        end
        chk("gap_done_end", a_done, 1'b1);
        chk("gap_val_end", a_ser_valid, 1'b0);
        @(negedge clk);

        // Strobe every 4th cycle; a mid-word offer of 0xFF must be ignored.
        seq8           = 8'b1000_0001;
        bit_en         = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'h81;
        a_if.msb_first = 1'b0;
        chk("slow_ready", a_if.in_ready, 1'b1);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("slow_bit%0d", k), a_ser_out, seq8[7 - k/4]);
            chk($sformatf("slow_val%0d", k), a_ser_valid, 1'b1);
            chk($sformatf("slow_done%0d", k), a_done, 1'b0);
            bit_en = ((k % 4) == 3);
            if (k == 10) begin
                a_if.in_valid = 1'b1;
                a_if.in_data  = 8'hFF;
            end
            if (k == 14) a_if.in_valid = 1'b0;
            @(negedge clk);
        end
        chk("slow_done", a_done, 1'b1);
        chk("slow_val_end", a_ser_valid, 1'b0);
        bit_en = 1'b1;
        @(negedge clk);

        // Reset during bit 3 of 0xA5 (LSB-first bits 1,0,1,0,...).
        seq8           = 8'b1010_0101;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 8'hA5;
        a_if.msb_first = 1'b0;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rstw_bit%0d", i), a_ser_out, seq8[7-i]);
            if (i < 3) @(negedge clk);
        end
        nrst = 1'b0;
        @(negedge clk);
        chk("rstw_val", a_ser_valid, 1'b0);
        chk("rstw_out", a_ser_out, 1'b0);
        chk("rstw_done", a_done, 1'b0);
        chk("rstw_ready", a_if.in_ready, 1'b0);
        nrst = 1'b1;
        @(negedge clk);
        chk("rstw_done2", a_done, 1'b0);
        chk("rstw_val2", a_ser_valid, 1'b0);
        send8("fresh", 8'hA5, 1'b0, 8'b1010_0101, 1'b0);

        // WIDTH=5 with a high idle level.
        seq5           = 5'b01100;
        bit_en         = 1'b1;
        b_if.in_valid  = 1'b1;
        b_if.in_data   = 5'b00110;
        b_if.msb_first = 1'b0;
        chk("w5_idle_out", b_ser_out, 1'b1);
        chk("w5_ready", b_if.in_ready, 1'b1);
        @(negedge clk);
        b_if.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("w5_bit%0d", i), b_ser_out, seq5[4-i]);
            chk($sformatf("w5_val%0d", i), b_ser_valid, 1'b1);
            chk($sformatf("w5_done%0d", i), b_done, 1'b0);
            @(negedge clk);
        end
        chk("w5_done", b_done, 1'b1);
        chk("w5_out_end", b_ser_out, 1'b1);
        chk("w5_val_end", b_ser_valid, 1'b0);
        @(negedge clk);
        chk("w5_done_clr", b_done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_stream_serializer.md
Name: piso_stream_serializer

Overview:
Parametrised parallel-to-serial converter with a ready/valid input handshake. It replaces fixed 8-bit LSB-first serialisers. Adds configurable word width, per-word bit order, a bit-rate strobe and a configurable idle line level. Supports gapless back-to-back words. Sits between a word-oriented producer (FIFO or register block) and a serial line driver.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32
IDLE_LEVEL, 1'b0, ser_out level whenever no word is being shifted
CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden

Ports:
clk  in  1  clock, rising edge
nrst  in  1  reset, synchronous, active-low
in_valid  in  1  producer has a word on in_data
in_ready  out  1  block accepts in_data this cycle
in_data  in  WIDTH  parallel word
msb_first  in  1  bit order for the word being accepted; sampled only on accept
bit_en  in  1  bit-rate strobe; tie to 1 for one bit per clk
ser_out  out  1  serial data
ser_valid  out  1  high while ser_out carries a data bit
done  out  1  one-cycle pulse when the last bit of a word retires

Behaviour:
- Reset: nrst is synchronous, active-low; clock is clk.
- Reset values: state=IDLE, bit counter=0, shift register=0, order flag=0, ser_valid=0, done=0, ser_out=IDLE_LEVEL. in_ready=0 while nrst is low.
- States:
  - IDLE, no word loaded.
  - SHIFT, a word is loaded and being shifted.
- in_ready (combinational) = nrst && (IDLE || (SHIFT && bit_en && cnt==WIDTH-1)).
- Accept = in_valid && in_ready at a rising edge.
- On accept:
  - Shift register <= in_data; order flag <= msb_first; cnt <= 0; state <= SHIFT.
  - Bit 0 of the frame is on ser_out from the accept edge onward. This bit is in_data[0] if LSB-first, in_data[WIDTH-1] if MSB-first.
  - Accept in IDLE ignores bit_en.
- In SHIFT, each edge with bit_en=1 retires the current bit:
  - If cnt<WIDTH-1: shift toward the output end (LSB-first: right shift, zero fill at MSB; MSB-first: left shift, zero fill at LSB); cnt <= cnt+1.
  - If cnt==WIDTH-1: done <= 1 for exactly one cycle. If in_valid is high, accept the new word and stay in SHIFT (gapless; ser_valid stays high). Otherwise go to IDLE.
- Edges with bit_en=0 hold all state; each bit is held until the next strobe.
- ser_out is registered-path only (no combinational path from in_data). It equals the output-end bit of the shift register while in SHIFT, else IDLE_LEVEL.
- ser_valid = (state==SHIFT).
- in_valid while in SHIFT with cnt<WIDTH-1 is ignored: no accept, the loaded word is unaffected, and the producer must hold the word.
- A change of msb_first mid-word has no effect; the order flag is latched per word.
- cnt never exceeds WIDTH-1; a default/illegal state recovers to IDLE.
- Reset mid-word: the next cycle shows IDLE values, the word is discarded, and no done pulse occurs.
- Latency: accept edge to last bit retired = WIDTH bit_en strobes. With bit_en=1, a word occupies exactly WIDTH cycles.

Test Plan:
- WIDTH=8, bit_en=1, msb_first=0, accept 0x1E -> ser_out 0,1,1,1,1,0,0,0 on the 8 cycles after accept; ser_valid high for those 8 cycles; done high on the cycle after the 8th bit; ser_out then 0.
- Same setup, msb_first=1, accept 0x1E -> ser_out 0,0,0,1,1,1,1,0; toggle msb_first mid-word -> sequence unchanged.
- in_valid held with 0x1E then 0xF0, LSB-first, bit_en=1 -> 16 contiguous bits 0,1,1,1,1,0,0,0,0,0,0,0,1,1,1,1; ser_valid never drops; two done pulses 8 cycles apart; in_ready high only on the accept cycles.
- bit_en high every 4th cycle, accept 0x81 LSB-first -> each bit held 4 cycles, 32 cycles total; in_valid with data 0xFF asserted mid-word is not accepted, and the output is unchanged.
- nrst low for 1 cycle during bit 3 of 0xA5 -> next cycle ser_valid=0, ser_out=IDLE_LEVEL, no done pulse; a fresh accept afterwards serialises correctly.
- WIDTH=5, IDLE_LEVEL=1, accept 5'b00110 LSB-first -> idle ser_out=1; bits 0,1,1,0,0; back to 1 after done.
